// File: rtl/alu_pkg.sv
// alu_pkg: shared command/state encodings and default widths
// for the alu_pipe two-operand ALU with a pipelined multiplier.
package alu_pkg;

    localparam int DWIDTH_DEF  = 8;
    localparam int CWIDTH_DEF  = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [3:0] {
        ADD     = 4'd0,
        SUB     = 4'd1,
        ADD_CIN = 4'd2,
        SUB_CIN = 4'd3,
        INC_A   = 4'd4,
        DEC_A   = 4'd5,
        INC_B   = 4'd6,
        DEC_B   = 4'd7,
        CMP     = 4'd8,
        MUL_INC = 4'd9,
        MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        AND     = 4'd0,
        NAND    = 4'd1,
        OR      = 4'd2,
        NOR     = 4'd3,
        XOR     = 4'd4,
        XNOR    = 4'd5,
        NOT_A   = 4'd6,
        NOT_B   = 4'd7,
        SHR1_A  = 4'd8,
        SHL1_A  = 4'd9,
        SHR1_B  = 4'd10,
        SHL1_B  = 4'd11,
        ROL_A_B = 4'd12,
        ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        MUL2
    } state_e;

    typedef struct packed {
        logic ok;
        logic need_a;
        logic need_b;
        logic mul;
    } op_info_t;

    // Which operands a command consumes, and whether it is a multiply
    function automatic op_info_t op_info(input logic mode, input logic [3:0] cmd);
        op_info_t r;
        r = '0;
        if (mode) begin
            case (arith_cmd_e'(cmd))
                ADD, SUB, ADD_CIN, SUB_CIN, CMP: begin
                    r.ok     = 1'b1;
                    r.need_a = 1'b1;
                    r.need_b = 1'b1;
                end
                INC_A, DEC_A: begin
                    r.ok     = 1'b1;
                    r.need_a = 1'b1;
                end
                INC_B, DEC_B: begin
                    r.ok     = 1'b1;
                    r.need_b = 1'b1;
                end
                MUL_INC, MUL_SHL: begin
                    r.ok     = 1'b1;
                    r.need_a = 1'b1;
                    r.need_b = 1'b1;
                    r.mul    = 1'b1;
                end
                default: r = '0;
            endcase
        end else begin
            case (logic_cmd_e'(cmd))
                AND, NAND, OR, NOR, XOR, XNOR, ROL_A_B, ROR_A_B: begin
                    r.ok     = 1'b1;
                    r.need_a = 1'b1;
                    r.need_b = 1'b1;
                end
                NOT_A, SHR1_A, SHL1_A: begin
                    r.ok     = 1'b1;
                    r.need_a = 1'b1;
                end
                NOT_B, SHR1_B, SHL1_B: begin
                    r.ok     = 1'b1;
                    r.need_b = 1'b1;
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// alu_mul_stage: first multiplier stage registers the conditioned
// factors; the product feeds the result register of alu_pipe.
module alu_mul_stage
    import alu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                shl_i,
    input  logic [DWIDTH-1:0]   a_i,
    input  logic [DWIDTH-1:0]   b_i,
    output logic [2*DWIDTH-1:0] prod_o
);

    localparam int AW = DWIDTH + 1;
    localparam int RW = 2 * DWIDTH;

    logic [AW-1:0] fa_d, fb_d;
    logic [AW-1:0] fa_q, fb_q;

    // Factor conditioning: (a<<1, b) or (a+1, b+1)
    always_comb begin
        if (shl_i) begin
            fa_d = {a_i, 1'b0};
            fb_d = {1'b0, b_i};
        end else begin
            fa_d = {1'b0, a_i} + AW'(1);
            fb_d = {1'b0, b_i} + AW'(1);
        end
    end

    // Factor register, loaded only when a multiply is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            fa_q <= '0;
            fb_q <= '0;
        end else if (load_i) begin
            fa_q <= fa_d;
            fb_q <= fb_d;
        end
    end

    assign prod_o = RW'(fa_q) * RW'(fb_q);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with operand-wait FSM, timeout and
// a two-cycle multiply path.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int CWIDTH  = CWIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                mode,
    input  logic [CWIDTH-1:0]   cmd,
    input  logic [1:0]          inp_valid,
    input  logic [DWIDTH-1:0]   opa,
    input  logic [DWIDTH-1:0]   opb,
    input  logic                cin,
    output logic [2*DWIDTH-1:0] res,
    output logic                cout,
    output logic                oflow,
    output logic                g,
    output logic                e,
    output logic                l,
    output logic                err,
    output logic                res_valid,
    output logic                busy
);

    localparam int AW = DWIDTH + 1;
    localparam int RW = 2 * DWIDTH;
    localparam int SW = $clog2(DWIDTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic [DWIDTH-1:0] opa_q, opb_q;
    logic [CWIDTH-1:0] cmd_q;
    logic              mode_q;
    logic [RW-1:0]     res_q;
    logic              cout_q, oflow_q, g_q, e_q, l_q, err_q;
    logic              rv_q, busy_q;

    logic [DWIDTH-1:0] a_x, b_x;
    logic [CWIDTH-1:0] cmd_x;
    logic [3:0]        cmd_lo;
    logic              mode_x;
    op_info_t          info;

    logic [RW-1:0]     alu_res;
    logic              alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;
    logic [AW-1:0]     sum, dif;
    logic              is_sum, is_dif;
    logic [DWIDTH-1:0] lr;
    logic [SW-1:0]     sh;
    logic              rot_bad;

    logic              missing, arrived;
    logic              do_alu, do_mul, do_fin, do_tmo, do_park, do_tick;
    logic [RW-1:0]     prod;

    // Operand/command source: live inputs, or latched ones while waiting
    always_comb begin
        a_x    = opa;
        b_x    = opb;
        cmd_x  = cmd;
        mode_x = mode;
        case (state_q)
            WAIT_A: begin
                b_x    = opb_q;
                cmd_x  = cmd_q;
                mode_x = mode_q;
            end
            WAIT_B: begin
                a_x    = opa_q;
                cmd_x  = cmd_q;
                mode_x = mode_q;
            end
            default: ;
        endcase
    end

    assign cmd_lo = cmd_x[3:0];

    // Command decode; any set bit above the 4-bit code is unlisted
    always_comb begin
        info = op_info(mode_x, cmd_lo);
        if ((cmd_x >> 4) != '0) info = '0;
    end

    // Single-cycle ALU datapath
    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_e     = 1'b0;
        alu_l     = 1'b0;
        alu_err   = 1'b0;
        sum       = '0;
        dif       = '0;
        is_sum    = 1'b0;
        is_dif    = 1'b0;
        lr        = '0;
        sh        = b_x[SW-1:0];
        rot_bad   = (b_x >> SW) != '0;
        if (!info.ok) begin
            alu_err = 1'b1;
        end else if (mode_x) begin
            case (arith_cmd_e'(cmd_lo))
                ADD:     begin sum = {1'b0, a_x} + {1'b0, b_x}; is_sum = 1'b1; end
                ADD_CIN: begin sum = {1'b0, a_x} + {1'b0, b_x} + AW'(cin); is_sum = 1'b1; end
                INC_A:   begin sum = {1'b0, a_x} + AW'(1); is_sum = 1'b1; end
                INC_B:   begin sum = {1'b0, b_x} + AW'(1); is_sum = 1'b1; end
                SUB:     begin dif = {1'b0, a_x} - {1'b0, b_x}; is_dif = 1'b1; end
                SUB_CIN: begin dif = {1'b0, a_x} - {1'b0, b_x} - AW'(cin); is_dif = 1'b1; end
                DEC_A:   begin dif = {1'b0, a_x} - AW'(1); is_dif = 1'b1; end
                DEC_B:   begin dif = {1'b0, b_x} - AW'(1); is_dif = 1'b1; end
                CMP: begin
                    alu_g = a_x > b_x;
                    alu_e = a_x == b_x;
                    alu_l = a_x < b_x;
                end
                default: ;
            endcase
            if (is_sum) begin
                alu_res  = RW'(sum);
                alu_cout = sum[DWIDTH];
            end
            if (is_dif) begin
                alu_res   = RW'(dif[DWIDTH-1:0]);
                alu_oflow = dif[DWIDTH];
            end
        end else begin
            case (logic_cmd_e'(cmd_lo))
                AND:    lr = a_x & b_x;
                NAND:   lr = ~(a_x & b_x);
                OR:     lr = a_x | b_x;
                NOR:    lr = ~(a_x | b_x);
                XOR:    lr = a_x ^ b_x;
                XNOR:   lr = ~(a_x ^ b_x);
                NOT_A:  lr = ~a_x;
                NOT_B:  lr = ~b_x;
                SHR1_A: lr = a_x >> 1;
                SHL1_A: lr = a_x << 1;
                SHR1_B: lr = b_x >> 1;
                SHL1_B: lr = b_x << 1;
                ROL_A_B: begin
                    if (rot_bad) alu_err = 1'b1;
                    else lr = (a_x << sh) | (a_x >> (DWIDTH - int'(sh)));
                end
                ROR_A_B: begin
                    if (rot_bad) alu_err = 1'b1;
                    else lr = (a_x >> sh) | (a_x << (DWIDTH - int'(sh)));
                end
                default: ;
            endcase
            alu_res = RW'(lr);
        end
    end

    assign missing = (info.need_a & ~inp_valid[0]) |
                     (info.need_b & ~inp_valid[1]);

    // Per-cycle action select; a one-operand cmd missing its operand is dropped
    always_comb begin
        arrived = 1'b0;
        do_alu  = 1'b0;
        do_mul  = 1'b0;
        do_fin  = 1'b0;
        do_tmo  = 1'b0;
        do_park = 1'b0;
        do_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (inp_valid != 2'b00) begin
                    if (!info.ok) do_alu = 1'b1;
                    else if (missing) do_park = info.need_a & info.need_b;
                    else if (info.mul) do_mul = 1'b1;
                    else do_alu = 1'b1;
                end
            end
            WAIT_A, WAIT_B: begin
                arrived = (state_q == WAIT_A) ? inp_valid[0] : inp_valid[1];
                if (arrived) begin
                    if (info.mul) do_mul = 1'b1;
                    else do_alu = 1'b1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    do_tmo = 1'b1;
                end else begin
                    do_tick = 1'b1;
                end
            end
            MUL2: do_fin = 1'b1;
            default: ;
        endcase
    end

    alu_mul_stage #(
        .DWIDTH (DWIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load_i (ce & do_mul),
        .shl_i  (arith_cmd_e'(cmd_lo) == MUL_SHL),
        .a_i    (a_x),
        .b_i    (b_x),
        .prod_o (prod)
    );

    // Control FSM with operand latches, timer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (ce) begin
            rv_q <= 1'b0;
            if (do_alu) begin
                res_q   <= alu_res;
                cout_q  <= alu_cout;
                oflow_q <= alu_oflow;
                g_q     <= alu_g;
                e_q     <= alu_e;
                l_q     <= alu_l;
                err_q   <= alu_err;
                rv_q    <= 1'b1;
                timer_q <= '0;
                state_q <= IDLE;
            end else if (do_tmo) begin
                res_q   <= '0;
                cout_q  <= 1'b0;
                oflow_q <= 1'b0;
                g_q     <= 1'b0;
                e_q     <= 1'b0;
                l_q     <= 1'b0;
                err_q   <= 1'b1;
                rv_q    <= 1'b1;
                timer_q <= '0;
                state_q <= IDLE;
            end else if (do_mul) begin
                busy_q  <= 1'b1;
                timer_q <= '0;
                state_q <= MUL2;
            end else if (do_fin) begin
                res_q   <= prod;
                cout_q  <= 1'b0;
                oflow_q <= 1'b0;
                g_q     <= 1'b0;
                e_q     <= 1'b0;
                l_q     <= 1'b0;
                err_q   <= 1'b0;
                rv_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end else if (do_park) begin
                opa_q   <= opa;
                opb_q   <= opb;
                cmd_q   <= cmd;
                mode_q  <= mode;
                timer_q <= '0;
                state_q <= inp_valid[0] ? WAIT_B : WAIT_A;
            end else if (do_tick) begin
                timer_q <= timer_q + TW'(1);
            end
        end else begin
            rv_q <= 1'b0;
        end
    end

    assign res       = res_q;
    assign cout      = cout_q;
    assign oflow     = oflow_q;
    assign g         = g_q;
    assign e         = e_q;
    assign l         = l_q;
    assign err       = err_q;
    assign res_valid = rv_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (DWIDTH=8)
// expected results queued at drive time, popped on res_valid.
module tb_alu_pipe;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int TO = 16;

    typedef logic [21:0] outv_t;

    logic          clk = 1'b0;
    logic          rst, ce, mode, cin;
    logic [CW-1:0] cmd;
    logic [1:0]    inp_valid;
    logic [DW-1:0] opa, opb;
    logic [15:0]   res;
    logic          cout, oflow, g, e, l, err, res_valid, busy;

    outv_t sb[$];
    outv_t last_exp;
    int    n_tests = 0;
    int    n_fail  = 0;

    alu_pipe #(
        .DWIDTH  (DW),
        .CWIDTH  (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .opa       (opa),
        .opb       (opb),
        .cin       (cin),
        .res       (res),
        .cout      (cout),
        .oflow     (oflow),
        .g         (g),
        .e         (e),
        .l         (l),
        .err       (err),
        .res_valid (res_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic outv_t outs();
        return {res, cout, oflow, g, e, l, err};
    endfunction

    function automatic outv_t model(bit m, int c, int a, int b, bit ci);
        int r;
        bit co, ov, gg, ee, ll, er;
        r = 0; co = 0; ov = 0; gg = 0; ee = 0; ll = 0; er = 0;
        if (m) begin
            case (c)
                0: begin r = a + b; co = r[8]; end
                1: begin r = (a - b) & 255; ov = a < b; end
                2: begin r = a + b + ci; co = r[8]; end
                3: begin r = (a - b - ci) & 255; ov = a < b + ci; end
                4: begin r = a + 1; co = r[8]; end
                5: begin r = (a - 1) & 255; ov = a == 0; end
                6: begin r = b + 1; co = r[8]; end
                7: begin r = (b - 1) & 255; ov = b == 0; end
                8: begin gg = a > b; ee = a == b; ll = a < b; end
                9: r = ((a + 1) * (b + 1)) & 'hFFFF;
                10: r = ((a * 2) * b) & 'hFFFF;
                default: er = 1;
            endcase
        end else begin
            case (c)
                0: r = a & b;
                1: r = ~(a & b) & 255;
                2: r = a | b;
                3: r = ~(a | b) & 255;
                4: r = a ^ b;
                5: r = ~(a ^ b) & 255;
                6: r = ~a & 255;
                7: r = ~b & 255;
                8: r = a >> 1;
                9: r = (a << 1) & 255;
                10: r = b >> 1;
                11: r = (b << 1) & 255;
                12: if (b > 7) er = 1; else r = ((a << b) | (a >> (8 - b))) & 255;
                13: if (b > 7) er = 1; else r = ((a >> b) | (a << (8 - b))) & 255;
                default: er = 1;
            endcase
        end
        return {r[15:0], co, ov, gg, ee, ll, er};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        outv_t x;
        @(posedge clk);
        #1;
        if (res_valid === 1'b1) begin
            check_eq("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                last_exp = x;
                check_eq("result", outs(), x);
            end
        end
    endtask

    task automatic drive(input bit m, input int c, input int a, input int b, input logic [1:0] v);
        mode      = m;
        cmd       = c[3:0];
        opa       = a[7:0];
        opb       = b[7:0];
        inp_valid = v;
    endtask

    task automatic op(input bit m, input int c, input int a, input int b, input logic [1:0] v);
        drive(m, c, a, b, v);
        tick();
        inp_valid = 2'b00;
    endtask

    task automatic push(input bit m, input int c, input int a, input int b);
        sb.push_back(model(m, c, a, b, cin));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n, rm, rc, ra, rb;
        rst = 1'b1; ce = 1'b1; mode = 1'b0; cmd = '0; cin = 1'b0;
        inp_valid = 2'b00; opa = '0; opb = '0; last_exp = '0;
        tick();
        tick();
        check_eq("rst_outs", outs(), 0);
        check_eq("rst_rv_busy", {res_valid, busy}, 0);
        rst = 1'b0;

        push(1, 0, 'hFF, 1);
        op(1, 0, 'hFF, 1, 2'b11);
        check_eq("add_rv", res_valid, 1);
        check_eq("add_res", {res, cout}, {16'h0100, 1'b1});

        push(1, 9, 3, 4);
        op(1, 9, 3, 4, 2'b11);
        check_eq("mul_busy", {busy, res_valid}, 2'b10);
        drive(1, 0, 1, 1, 2'b11);
        tick();
        inp_valid = 2'b00;
        check_eq("mul_done", {busy, res_valid}, 2'b01);
        check_eq("mul_res", res, 16'h0014);
        tick();
        check_eq("busy_ignored", res_valid, 0);

        op(1, 1, 0, 5, 2'b10);
        check_eq("wait_rv", res_valid, 0);
        repeat (3) tick();
        push(1, 1, 3, 5);
        op(0, 4, 3, 'h99, 2'b01);
        check_eq("sub_late_rv", res_valid, 1);
        check_eq("sub_late", {res, oflow}, {16'h00FE, 1'b1});

        op(1, 0, 9, 9, 2'b00);
        check_eq("noop_rv", res_valid, 0);
        check_eq("noop_hold", outs(), last_exp);

        for (int w = 0; w < 2; w++) begin
            sb.push_back({16'h0, 6'b000001});
            op(1, 0, 7, 0, 2'b01);
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                ce = (w == 0) || !(i >= 6 && i <= 9);
                tick();
                n = i;
                if (res_valid === 1'b1) break;
            end
            ce = 1'b1;
            check_eq("tmo_latency", n, (w == 0) ? 16 : 20);
            check_eq("tmo_err", {err, res}, {1'b1, 16'h0});
        end

        push(1, 8, 5, 5); op(1, 8, 5, 5, 2'b11);
        check_eq("cmp_eq", {g, e, l}, 3'b010);
        push(1, 8, 9, 3); op(1, 8, 9, 3, 2'b11);
        check_eq("cmp_gt", {g, e, l}, 3'b100);
        push(1, 8, 2, 7); op(1, 8, 2, 7, 2'b11);
        check_eq("cmp_lt", {g, e, l}, 3'b001);
        push(0, 12, 'h81, 10); op(0, 12, 'h81, 10, 2'b11);
        check_eq("rol_err", {err, res}, {1'b1, 16'h0});
        push(0, 12, 'h81, 1); op(0, 12, 'h81, 1, 2'b11);
        check_eq("rol_1", res, 16'h0003);
        push(0, 13, 'h81, 3); op(0, 13, 'h81, 3, 2'b11);
        check_eq("ror_3", res, 16'h0030);

        push(1, 6, 0, 'hFF); op(1, 6, 0, 'hFF, 2'b10);
        check_eq("inc_b", {res, cout}, {16'h0100, 1'b1});
        push(1, 5, 0, 0); op(1, 5, 0, 0, 2'b01);
        check_eq("dec_a", {res, oflow}, {16'h00FF, 1'b1});
        push(1, 12, 1, 2); op(1, 12, 1, 2, 2'b11);
        check_eq("bad_arith", {err, res_valid}, 2'b11);
        push(0, 15, 1, 2); op(0, 15, 1, 2, 2'b11);
        check_eq("bad_logic", {err, res_valid}, 2'b11);

        push(1, 10, 3, 4); op(1, 10, 3, 4, 2'b11);
        tick();
        check_eq("mul_shl", res, 16'h0018);

        repeat (60) begin
            rm = $urandom_range(0, 1);
            rc = $urandom_range(0, 15);
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            cin = 1'($urandom_range(0, 1));
            push(rm[0], rc, ra, rb);
            op(rm[0], rc, ra, rb, 2'b11);
            if (rm == 1 && (rc == 9 || rc == 10)) begin
                check_eq("rand_busy", busy, 1);
                tick();
            end
            check_eq("rand_rv", res_valid, 1);
        end
        cin = 1'b0;

        op(1, 10, 3, 4, 2'b11);
        check_eq("mul2_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mul_outs", outs(), 0);
        check_eq("rst_mul_rv_busy", {res_valid, busy}, 0);
        tick();
        check_eq("rst_mul_quiet", res_valid, 0);

        check_eq("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
